// File: rtl/hysteresis_stream.sv
// rtl/hysteresis_stream.sv - streaming 3x3 hysteresis-threshold stage (canny pipeline)
//
// Purpose: pops raster-order magnitude pixels from an input FIFO, keeps two rows
// plus three pixels in a shift-register line buffer, and pushes one thresholded
// pixel per input pixel to an output FIFO at up to one pixel per clock.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high
//   in_rd_en     out  pop input FIFO this cycle
//   in_empty     in   input FIFO empty
//   in_dout      in   input pixel (raster order)
//   out_wr_en    out  push output FIFO this cycle
//   out_full     in   output FIFO full
//   out_din      out  output pixel
//   high_thresh  in   strong threshold, sampled on the first pop of a frame
//   low_thresh   in   weak threshold, sampled on the first pop of a frame
//   frame_done   out  1-cycle pulse with the last output pixel of a frame
//   strong_count out  strong non-border centre count (HYSTERESIS_STRONG_COUNT_EN only)
//
// Optional feature macro: HYSTERESIS_STRONG_COUNT_EN
module hysteresis_stream #(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int PIXEL_BITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in_rd_en,
    input  logic                  in_empty,
    input  logic [PIXEL_BITS-1:0] in_dout,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [PIXEL_BITS-1:0] out_din,
    input  logic [PIXEL_BITS-1:0] high_thresh,
    input  logic [PIXEL_BITS-1:0] low_thresh,
`ifdef HYSTERESIS_STRONG_COUNT_EN
    output logic                  frame_done,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] strong_count
`else
    output logic                  frame_done
`endif
);

    localparam int LB   = 2 * WIDTH + 3;
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int PW   = $clog2(NPIX + 1);
    localparam int CW   = $clog2(WIDTH);
    localparam int RW   = $clog2(HEIGHT);
    localparam int QW   = $clog2(WIDTH + 2);

    localparam logic [0:0] ST_PROLOGUE = 1'b0;
    localparam logic [0:0] ST_RUN      = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [QW-1:0]         pcnt_q, pcnt_d;
    logic [PW-1:0]         p_q, p_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [PIXEL_BITS-1:0] hi_q, hi_d;
    logic [PIXEL_BITS-1:0] lo_q, lo_d;
    logic [PIXEL_BITS-1:0] lb_q [LB];

    logic                  pro_pop;
    logic                  src_real;
    logic                  src_ok;
    logic                  advance;
    logic                  last_pix;
    logic                  shift_en;
    logic [PIXEL_BITS-1:0] shift_val;
    logic [PIXEL_BITS-1:0] centre;
    logic                  nb_strong;
    logic                  border;
    logic                  centre_strong;
    logic [PIXEL_BITS-1:0] pix_val;

    // Window taps: index 0 is the oldest pixel (row-1, col-1); the centre sits at WIDTH+1.
    always_comb begin
        centre    = lb_q[WIDTH + 1];
        nb_strong = (lb_q[0]         > hi_q) || (lb_q[1]         > hi_q) ||
                    (lb_q[2]         > hi_q) || (lb_q[WIDTH]     > hi_q) ||
                    (lb_q[WIDTH + 2] > hi_q) || (lb_q[2*WIDTH]   > hi_q) ||
                    (lb_q[2*WIDTH+1] > hi_q) || (lb_q[2*WIDTH+2] > hi_q);
        // Border pixels are forced to 0, which also hides the column wrap of the window.
        border    = (row_q == '0) || (row_q == RW'(HEIGHT - 1)) ||
                    (col_q == '0) || (col_q == CW'(WIDTH - 1));
        centre_strong = !border && (centre > hi_q);
        if (border) begin
            pix_val = '0;
        end else if ((centre > hi_q) || ((centre > lo_q) && nb_strong)) begin
            pix_val = centre;
        end else begin
            pix_val = '0;
        end
    end

    // Handshake: pops depend only on state, counters, in_empty and out_full.
    always_comb begin
        pro_pop  = (state_q == ST_PROLOGUE) && !in_empty && !reset;
        // Once the pixel feeding the window lies past the frame end, zeros are shifted in.
        src_real = (32'(p_q) + 32'(WIDTH + 2)) < 32'(NPIX);
        src_ok   = src_real ? !in_empty : 1'b1;
        advance  = (state_q == ST_RUN) && src_ok && !out_full && !reset;
        last_pix = (p_q == PW'(NPIX - 1));

        in_rd_en   = pro_pop || (advance && src_real);
        out_wr_en  = advance;
        frame_done = advance && last_pix;
        out_din    = advance ? pix_val : '0;

        shift_en  = pro_pop || advance;
        shift_val = (pro_pop || src_real) ? in_dout : '0;
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        p_d     = p_q;
        col_d   = col_q;
        row_d   = row_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (pro_pop) begin
            if (pcnt_q == '0) begin
                hi_d = high_thresh;
                lo_d = low_thresh;
            end
            if (pcnt_q == QW'(WIDTH + 1)) begin
                pcnt_d  = '0;
                state_d = ST_RUN;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
        if (advance) begin
            if (last_pix) begin
                p_d     = '0;
                col_d   = '0;
                row_d   = '0;
                state_d = ST_PROLOGUE;
            end else begin
                p_d = p_q + 1'b1;
                if (col_q == CW'(WIDTH - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_PROLOGUE;
            pcnt_q  <= '0;
            p_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            p_q     <= p_d;
            col_q   <= col_d;
            row_q   <= row_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Line buffer is wiped at frame end so the next frame's top border never sees stale data.
    always_ff @(posedge clock) begin
        if (reset || frame_done) begin
            for (int i = 0; i < LB; i++) begin
                lb_q[i] <= '0;
            end
        end else if (shift_en) begin
            for (int i = 0; i < LB - 1; i++) begin
                lb_q[i] <= lb_q[i + 1];
            end
            lb_q[LB - 1] <= shift_val;
        end
    end

`ifdef HYSTERESIS_STRONG_COUNT_EN
    localparam int SCW = $clog2(NPIX + 1);

    logic [SCW-1:0] sc_q, sc_d;

    // Restarting on the first push keeps the previous frame's total visible until then.
    always_comb begin
        sc_d = sc_q;
        if (advance) begin
            if (p_q == '0) begin
                sc_d = SCW'(centre_strong);
            end else begin
                sc_d = sc_q + SCW'(centre_strong);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sc_q <= '0;
        end else begin
            sc_q <= sc_d;
        end
    end

    assign strong_count = sc_q;
`endif

endmodule

// File: tb/tb_hysteresis_stream.sv
// tb/tb_hysteresis_stream.sv - randomized self-checking bench for hysteresis_stream
module tb_hysteresis_stream;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_rd_en;
    logic       in_empty;
    logic [7:0] in_dout;
    logic       out_wr_en;
    logic       out_full;
    logic [7:0] out_din;
    logic [7:0] high_thresh;
    logic [7:0] low_thresh;
    logic       frame_done;
`ifdef HYSTERESIS_STRONG_COUNT_EN
    logic [5:0] strong_count;
`endif

    hysteresis_stream #(.WIDTH(W), .HEIGHT(H), .PIXEL_BITS(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_rd_en    (in_rd_en),
        .in_empty    (in_empty),
        .in_dout     (in_dout),
        .out_wr_en   (out_wr_en),
        .out_full    (out_full),
        .out_din     (out_din),
        .high_thresh (high_thresh),
        .low_thresh  (low_thresh),
`ifdef HYSTERESIS_STRONG_COUNT_EN
        .frame_done  (frame_done),
        .strong_count(strong_count)
`else
        .frame_done  (frame_done)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0] img  [N];
    logic [7:0] expv [N];
    logic [7:0] inq  [$];
    logic [7:0] outq [$];
    int pops, pushes, fd_cnt, fd_at, first_push_pops, bad_push, bad_pop, bad_fd, exp_strong;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference: hysteresis rule applied directly on the 2-D image.
    function automatic logic [7:0] model_pix(input int r, input int c,
                                             input logic [7:0] hi, input logic [7:0] lo);
        logic [7:0] v;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
        v = img[r * W + c];
        if (v > hi) return v;
        if (v <= lo) return 8'd0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && img[(r + dr) * W + c + dc] > hi) return v;
        return 8'd0;
    endfunction

    task automatic clear_img();
        for (int i = 0; i < N; i++) img[i] = 8'd0;
    endtask

    task automatic idle_inputs();
        @(negedge clock);
        in_empty = 1'b1;
        in_dout  = 8'd0;
        out_full = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int pe, input int pf,
                             input logic [7:0] hi, input logic [7:0] lo,
                             input int chg_at, input logic [7:0] hi2, input logic [7:0] lo2,
                             input int abort_at);
        int cyc;
        exp_strong = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                expv[r * W + c] = model_pix(r, c, hi, lo);
                if (r > 0 && r < H - 1 && c > 0 && c < W - 1 && img[r * W + c] > hi) exp_strong++;
            end
        inq.delete();
        outq.delete();
        for (int i = 0; i < N; i++) inq.push_back(img[i]);
        pops = 0; pushes = 0; fd_cnt = 0; fd_at = 0; first_push_pops = 0;
        bad_push = 0; bad_pop = 0; bad_fd = 0;
        high_thresh = hi;
        low_thresh  = lo;
        cyc = 0;
        while (pushes < N && cyc < 3000 && !(abort_at > 0 && pushes >= abort_at)) begin
            @(negedge clock);
            cyc++;
            if (chg_at > 0 && pushes >= chg_at) begin
                high_thresh = hi2;
                low_thresh  = lo2;
            end
            in_empty = (inq.size() == 0) || ($urandom_range(0, 99) < pe);
            in_dout  = in_empty ? 8'd0 : inq[0];
            out_full = ($urandom_range(0, 99) < pf);
            #1;
            if (in_rd_en) begin
                if (in_empty) bad_pop++;
                else void'(inq.pop_front());
                pops++;
            end
            if (out_wr_en) begin
                if (out_full) bad_push++;
                outq.push_back(out_din);
                pushes++;
                if (pushes == 1) first_push_pops = pops;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_at = pushes;
                if (!out_wr_en) bad_fd++;
            end
        end
        if (abort_at > 0) begin
            check_eq({tag, " pushes before abort"}, pushes, abort_at);
        end else begin
            idle_inputs();
            check_eq({tag, " push count"}, outq.size(), N);
            for (int i = 0; i < N && i < outq.size(); i++)
                check_eq($sformatf("%s px(%0d,%0d)", tag, i / W, i % W), outq[i], expv[i]);
            check_eq({tag, " pops"}, pops, N);
            check_eq({tag, " frame_done count"}, fd_cnt, 1);
            check_eq({tag, " frame_done at push"}, fd_at, N);
            check_eq({tag, " frame_done without push"}, bad_fd, 0);
            check_eq({tag, " push while full"}, bad_push, 0);
            check_eq({tag, " pop while empty"}, bad_pop, 0);
        end
    endtask

    task automatic check_quiet(input string tag);
        #1;
        check_eq({tag, " in_rd_en"}, in_rd_en, 0);
        check_eq({tag, " out_wr_en"}, out_wr_en, 0);
        check_eq({tag, " out_din"}, out_din, 0);
        check_eq({tag, " frame_done"}, frame_done, 0);
    endtask

    initial begin
        reset = 1'b1; in_empty = 1'b1; in_dout = 8'd0; out_full = 1'b0;
        high_thresh = 8'd0; low_thresh = 8'd0;
        @(negedge clock);
        @(negedge clock);
        in_empty = 1'b0;
        in_dout  = 8'h5A;
        check_quiet("reset");
`ifdef HYSTERESIS_STRONG_COUNT_EN
        check_eq("reset strong_count", strong_count, 0);
`endif
        @(negedge clock);
        reset = 1'b0;
        in_empty = 1'b1;

        // 1: all-zero frame, no stalls
        clear_img();
        run_frame("t1", 0, 0, 8'd48, 8'd12, 0, 8'd0, 8'd0, 0);
        check_eq("t1 pops at first push", first_push_pops, W + 3);

        // 2: weak pixel next to a strong one survives, isolated weak one does not
        clear_img();
        img[2 * W + 3] = 8'd60;
        img[2 * W + 4] = 8'd20;
        img[4 * W + 4] = 8'd20;
        run_frame("t2", 0, 0, 8'd48, 8'd12, 0, 8'd0, 8'd0, 0);
        if (outq.size() == N) begin
            check_eq("t2 (2,3)", outq[2 * W + 3], 60);
            check_eq("t2 (2,4)", outq[2 * W + 4], 20);
            check_eq("t2 (4,4)", outq[4 * W + 4], 0);
        end
`ifdef HYSTERESIS_STRONG_COUNT_EN
        check_eq("t2 strong_count", strong_count, exp_strong);
`endif

        // 3: strong corners are border pixels
        clear_img();
        img[0]         = 8'd200;
        img[N - 1]     = 8'd200;
        img[W + 1]     = 8'd30;
        img[4 * W + 6] = 8'd5;
        run_frame("t3", 0, 0, 8'd48, 8'd12, 0, 8'd0, 8'd0, 0);

        // 4: random images under random backpressure and starvation
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 80));
            run_frame($sformatf("t4f%0d", f), 30, 50, 8'd48, 8'd12, 0, 8'd0, 8'd0, 0);
`ifdef HYSTERESIS_STRONG_COUNT_EN
            check_eq($sformatf("t4f%0d strong_count", f), strong_count, exp_strong);
`endif
        end

        // 5: threshold change mid-frame takes effect only on the next frame
        clear_img();
        img[3 * W + 3] = 8'd11;
        run_frame("t5f1", 20, 20, 8'd48, 8'd12, 10, 8'd10, 8'd5, 0);
        if (outq.size() == N) check_eq("t5f1 (3,3)", outq[3 * W + 3], 0);
        run_frame("t5f2", 20, 20, 8'd10, 8'd5, 0, 8'd0, 8'd0, 0);
        if (outq.size() == N) check_eq("t5f2 (3,3)", outq[3 * W + 3], 11);

        // 6: reset mid-frame, then a clean frame
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 80));
        run_frame("t6a", 20, 20, 8'd48, 8'd12, 0, 8'd0, 8'd0, 20);
        @(negedge clock);
        reset = 1'b1; in_empty = 1'b0; in_dout = 8'hAA; out_full = 1'b0;
        check_quiet("t6 reset c1");
        @(negedge clock);
        check_quiet("t6 reset c2");
        @(negedge clock);
        reset = 1'b0; in_empty = 1'b1; in_dout = 8'd0;
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 80));
        run_frame("t6b", 30, 30, 8'd40, 8'd10, 0, 8'd0, 8'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
